// File: rtl/alu_requester_if.sv
// Shared ALU types, the ALU file interface, and the request/response
// interface for alu_requester.

package alu_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL,
    ALU_SRL,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU
  } aluop_t;
endpackage

// Connection to the combinational ALU.
interface alu_file_if;
  import alu_pkg::*;
  word_t  porta;
  word_t  portb;
  aluop_t ALUOP;
  word_t  outport;
  logic   neg;
  logic   zero;
  logic   over;

  modport alu (input porta, portb, ALUOP, output outport, neg, zero, over);
  modport tb  (output porta, portb, ALUOP, input outport, neg, zero, over);
endinterface

// Request/response handshake bundle between a request source and alu_requester.
interface alu_requester_if #(
  parameter int TAG_W = 4
);
  import alu_pkg::*;
  logic             req_valid;
  logic             req_ready;
  aluop_t           req_op;
  word_t            req_a;
  word_t            req_b;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             rsp_valid;
  logic             rsp_ready;
  word_t            rsp_result;
  logic             rsp_neg;
  logic             rsp_zero;
  logic             rsp_over;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic [15:0]      ops_done;
  logic [7:0]       over_cnt;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_neg, rsp_zero, rsp_over,
           rsp_tag, busy, ops_done, over_cnt
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_neg, rsp_zero, rsp_over,
           rsp_tag, busy, ops_done, over_cnt
  );
endinterface

// File: rtl/alu_requester.sv
// Sequential initiator for a combinational ALU: queues requests in a small
// FIFO, issues one per cycle from the head, and registers result, flags and
// tag into a single response stage with completion/overflow statistics.

module alu_requester #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic           CLK,
  input  logic           RST,
  alu_file_if.tb         aluif,
  alu_requester_if.slave rq
);
  import alu_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Over-count saturates rather than wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  aluop_t           op_mem_q  [DEPTH];
  word_t            a_mem_q   [DEPTH];
  word_t            b_mem_q   [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             rsp_valid_q, rsp_valid_d;
  word_t            rsp_result_q, rsp_result_d;
  logic             rsp_neg_q, rsp_neg_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_over_q, rsp_over_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [15:0]      ops_done_q, ops_done_d;
  logic [7:0]       over_cnt_q, over_cnt_d;

  logic empty, full, push, issue, rsp_hs;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNT_W'(DEPTH));
  // Ready depends only on occupancy and flush, never on rsp_ready.
  assign rq.req_ready = !full && !rq.flush;
  assign push   = rq.req_valid && rq.req_ready;
  assign issue  = !empty && (!rsp_valid_q || rq.rsp_ready);
  assign rsp_hs = rsp_valid_q && rq.rsp_ready;

  // Head entry drives the ALU directly; idle inputs are zero.
  assign aluif.porta = empty ? '0 : a_mem_q[rd_ptr_q];
  assign aluif.portb = empty ? '0 : b_mem_q[rd_ptr_q];
  assign aluif.ALUOP = empty ? aluop_t'(4'd0) : op_mem_q[rd_ptr_q];

  assign rq.rsp_valid  = rsp_valid_q;
  assign rq.rsp_result = rsp_result_q;
  assign rq.rsp_neg    = rsp_neg_q;
  assign rq.rsp_zero   = rsp_zero_q;
  assign rq.rsp_over   = rsp_over_q;
  assign rq.rsp_tag    = rsp_tag_q;
  assign rq.busy       = !empty || rsp_valid_q;
  assign rq.ops_done   = ops_done_q;
  assign rq.over_cnt   = over_cnt_q;

  // Next-state for FIFO pointers, response stage and statistics.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_neg_d    = rsp_neg_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_over_d   = rsp_over_q;
    rsp_tag_d    = rsp_tag_q;
    ops_done_d   = ops_done_q;
    over_cnt_d   = over_cnt_q;

    if (rq.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      rsp_valid_d = 1'b0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (issue) rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(issue);
      if (issue) begin
        rsp_valid_d  = 1'b1;
        rsp_result_d = aluif.outport;
        rsp_neg_d    = aluif.neg;
        rsp_zero_d   = aluif.zero;
        rsp_over_d   = aluif.over;
        rsp_tag_d    = tag_mem_q[rd_ptr_q];
      end else if (rsp_hs) begin
        rsp_valid_d = 1'b0;
      end
    end

    // A handshake still counts in a flush cycle.
    if (rsp_hs) begin
      ops_done_d = ops_done_q + 16'd1;
      if (rsp_over_q) over_cnt_d = sat_inc8(over_cnt_q);
    end
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_neg_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_over_q   <= 1'b0;
      rsp_tag_q    <= '0;
      ops_done_q   <= '0;
      over_cnt_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_neg_q    <= rsp_neg_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_over_q   <= rsp_over_d;
      rsp_tag_q    <= rsp_tag_d;
      ops_done_q   <= ops_done_d;
      over_cnt_q   <= over_cnt_d;
    end
  end

  // FIFO storage; contents are qualified by the count, so no reset needed.
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      op_mem_q[wr_ptr_q]  <= rq.req_op;
      a_mem_q[wr_ptr_q]   <= rq.req_a;
      b_mem_q[wr_ptr_q]   <= rq.req_b;
      tag_mem_q[wr_ptr_q] <= rq.req_tag;
    end
  end
endmodule

// File: tb/tb_alu_requester.sv
// Directed bench for alu_requester with a behavioural combinational ALU.

module tb_alu_requester;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic        neg;
    logic        zero;
    logic        over;
  } alu_res_t;

  logic CLK;
  logic RST;
  int   vectors = 0;
  int   miscompares = 0;
  alu_res_t exp_res [20];

  alu_file_if afi ();
  alu_requester_if #(.TAG_W(4)) rq ();

  alu_requester #(.DEPTH(4), .TAG_W(4)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .aluif (afi),
    .rq    (rq)
  );

  function automatic alu_res_t alu_ref(input aluop_t op, input logic [31:0] a, input logic [31:0] b);
    alu_res_t r;
    logic [31:0] s;
    r.over = 1'b0;
    case (op)
      ALU_SLL:  s = a << b[4:0];
      ALU_SRL:  s = a >> b[4:0];
      ALU_ADD: begin
        s = a + b;
        r.over = (a[31] == b[31]) && (s[31] != a[31]);
      end
      ALU_SUB: begin
        s = a - b;
        r.over = (a[31] != b[31]) && (s[31] != a[31]);
      end
      ALU_AND:  s = a & b;
      ALU_OR:   s = a | b;
      ALU_XOR:  s = a ^ b;
      ALU_NOR:  s = ~(a | b);
      ALU_SLT:  s = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: s = {31'd0, (a < b)};
      default:  s = 32'd0;
    endcase
    r.res  = s;
    r.neg  = s[31];
    r.zero = (s == 32'd0);
    return r;
  endfunction

  always_comb begin
    alu_res_t r;
    r = alu_ref(afi.ALUOP, afi.porta, afi.portb);
    afi.outport = r.res;
    afi.neg     = r.neg;
    afi.zero    = r.zero;
    afi.over    = r.over;
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input aluop_t op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    rq.req_valid = 1'b1;
    rq.req_op    = op;
    rq.req_a     = a;
    rq.req_b     = b;
    rq.req_tag   = t;
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_req_ready"},  rq.req_ready, 1);
    chk({pfx, "_rsp_valid"},  rq.rsp_valid, 0);
    chk({pfx, "_rsp_result"}, rq.rsp_result, 0);
    chk({pfx, "_rsp_flags"},  {rq.rsp_neg, rq.rsp_zero, rq.rsp_over}, 0);
    chk({pfx, "_rsp_tag"},    rq.rsp_tag, 0);
    chk({pfx, "_busy"},       rq.busy, 0);
    chk({pfx, "_ops_done"},   rq.ops_done, 0);
    chk({pfx, "_over_cnt"},   rq.over_cnt, 0);
  endtask

  initial begin
    RST = 1'b1;
    rq.req_valid = 1'b0;
    rq.req_op    = ALU_ADD;
    rq.req_a     = '0;
    rq.req_b     = '0;
    rq.req_tag   = '0;
    rq.flush     = 1'b0;
    rq.rsp_ready = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    chk_reset_state("reset");

    // Single ADD 5+7 tag 3
    rq.rsp_ready = 1'b1;
    drive(ALU_ADD, 32'd5, 32'd7, 4'd3);
    tick();
    rq.req_valid = 1'b0;
    chk("add_porta_cyc1", afi.porta, 5);
    chk("add_valid_cyc1", rq.rsp_valid, 0);
    tick();
    chk("add_valid_cyc2", rq.rsp_valid, 1);
    chk("add_result", rq.rsp_result, 12);
    chk("add_flags", {rq.rsp_neg, rq.rsp_zero, rq.rsp_over}, 3'b000);
    chk("add_tag", rq.rsp_tag, 3);
    tick();
    chk("add_ops_done", rq.ops_done, 1);
    chk("add_valid_drop", rq.rsp_valid, 0);
    chk("add_busy", rq.busy, 0);

    // Overflow then zero result
    drive(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 4'd1);
    tick();
    drive(ALU_SUB, 32'd4, 32'd4, 4'd2);
    tick();
    rq.req_valid = 1'b0;
    chk("ovf_result", rq.rsp_result, 32'h8000_0000);
    chk("ovf_flags", {rq.rsp_neg, rq.rsp_zero, rq.rsp_over}, 3'b101);
    tick();
    chk("ovf_over_cnt", rq.over_cnt, 1);
    chk("sub_result", rq.rsp_result, 0);
    chk("sub_flags", {rq.rsp_neg, rq.rsp_zero, rq.rsp_over}, 3'b010);
    chk("sub_tag", rq.rsp_tag, 2);
    tick();
    chk("sub_over_cnt", rq.over_cnt, 1);
    chk("sub_ops_done", rq.ops_done, 3);

    // Backpressure until full
    rq.rsp_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      drive(ALU_ADD, 32'(t), 32'd100, 4'(t));
      tick();
    end
    drive(ALU_ADD, 32'd5, 32'd100, 4'd5);
    #1;
    chk("bp_full_ready", rq.req_ready, 0);
    chk("bp_tag", rq.rsp_tag, 0);
    chk("bp_busy", rq.busy, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_ready", rq.req_ready, 0);
      chk("bp_hold_valid", rq.rsp_valid, 1);
      chk("bp_hold_tag", rq.rsp_tag, 0);
      chk("bp_hold_result", rq.rsp_result, 100);
    end
    rq.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("bp_drain_valid", rq.rsp_valid, 1);
      chk("bp_drain_tag", rq.rsp_tag, k);
      chk("bp_drain_result", rq.rsp_result, 100 + k);
      if (k == 1) chk("bp_ready_after_pop", rq.req_ready, 1);
      tick();
      if (k == 1) rq.req_valid = 1'b0;
    end
    chk("bp_empty_valid", rq.rsp_valid, 0);
    chk("bp_ops_done", rq.ops_done, 9);

    // Streaming 20 mixed ops from a fresh reset
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("stream_ops_reset", rq.ops_done, 0);
    rq.rsp_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      if (c < 2) begin
        chk("stream_fill", rq.rsp_valid, 0);
      end else begin
        chk("stream_valid", rq.rsp_valid, 1);
        chk("stream_result", rq.rsp_result, exp_res[c-2].res);
        chk("stream_flags", {rq.rsp_neg, rq.rsp_zero, rq.rsp_over},
            {exp_res[c-2].neg, exp_res[c-2].zero, exp_res[c-2].over});
        chk("stream_tag", rq.rsp_tag, (c - 2) & 15);
      end
      if (c < 20) begin
        logic [31:0] a, b;
        aluop_t op;
        op = aluop_t'(4'(c % 10));
        a = 32'h1234_5678 * 32'(c + 1);
        b = 32'h0F0F_00FF + 32'(c * 3);
        exp_res[c] = alu_ref(op, a, b);
        drive(op, a, b, 4'(c));
      end else begin
        rq.req_valid = 1'b0;
      end
      tick();
    end
    chk("stream_end_valid", rq.rsp_valid, 0);
    chk("stream_ops_done", rq.ops_done, 20);

    // Flush with 3 queued requests
    rq.rsp_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      drive(ALU_OR, 32'(t), 32'd0, 4'(t));
      tick();
    end
    drive(ALU_OR, 32'd7, 32'd0, 4'd7);
    rq.flush = 1'b1;
    rq.rsp_ready = 1'b1;
    #1;
    chk("flush_req_ready", rq.req_ready, 0);
    tick();
    rq.flush = 1'b0;
    rq.req_valid = 1'b0;
    chk("flush_valid", rq.rsp_valid, 0);
    chk("flush_busy", rq.busy, 0);
    chk("flush_ops_done", rq.ops_done, 21);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_quiet_valid", rq.rsp_valid, 0);
      chk("flush_quiet_busy", rq.busy, 0);
    end

    // Reset mid-stream
    for (int t = 0; t < 3; t++) begin
      drive(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 4'(t + 9));
      tick();
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    rq.req_valid = 1'b0;
    chk_reset_state("midrst");
    tick();
    tick();
    chk("midrst_quiet_valid", rq.rsp_valid, 0);
    chk("midrst_quiet_busy", rq.busy, 0);

    // ops_done wrap after 65537 handshakes
    drive(ALU_ADD, 32'd0, 32'd0, 4'd0);
    repeat (65537) tick();
    rq.req_valid = 1'b0;
    repeat (3) tick();
    chk("wrap_ops_done", rq.ops_done, 1);
    chk("wrap_over_cnt", rq.over_cnt, 0);

    // over_cnt saturation after 300 overflowing ADDs
    drive(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 4'd0);
    repeat (300) tick();
    rq.req_valid = 1'b0;
    repeat (3) tick();
    chk("sat_over_cnt", rq.over_cnt, 255);
    chk("sat_ops_done", rq.ops_done, 301);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_requester.md
# alu_requester

Sequential initiator for the ALU interface: accepts ALU operation requests over a valid/ready handshake, buffers them in a small FIFO, and drives the combinational ALU one operation per cycle through the `alu_file_if.tb` modport. Each ALU result and its flags are registered and returned on a valid/ready response port. The block sits between a request source (sequencer, BIST engine, or multicycle unit) and the ALU, and also keeps completion and overflow statistics.

## Interface
- DEPTH, 4: request FIFO entries; power of two, minimum 2.
- TAG_W, 4: width of the opaque request tag returned with each response.
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- aluif  alu_file_if.tb  drives porta, portb, ALUOP; samples outport, neg, zero, over.
- req_valid  in  1  request present.
- req_ready  out  1  request FIFO can accept.
- req_op  in  aluop_t  ALU operation.
- req_a, req_b  in  word_t (32)  operands.
- req_tag  in  TAG_W  tag echoed on the response.
- flush  in  1  synchronous drop of all queued and pending work.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  word_t  captured outport.
- rsp_neg, rsp_zero, rsp_over  out  1 each  captured flags.
- rsp_tag  out  TAG_W  tag of the captured request.
- busy  out  1  equals FIFO not empty OR rsp_valid.
- ops_done  out  16  count of completed response handshakes.
- over_cnt  out  8  count of completed responses with rsp_over=1.

## Operation
- Request side: push occurs when req_valid && req_ready. req_ready = !full. req_ready does not depend on rsp_ready in the same cycle, so there is no combinational path from rsp_ready to req_ready.
- FIFO: uses circular read/write pointers plus an occupancy count of width clog2(DEPTH)+1. A simultaneous push and pop leaves the count unchanged. Pointers wrap from DEPTH-1 to 0.
- ALU drive: when the FIFO is non-empty, porta, portb, and ALUOP come combinationally from the head entry. When the FIFO is empty, porta and portb are 0 and ALUOP is aluop_t'(0).
- Issue rule: issue = !empty && (!rsp_valid || rsp_ready). On issue:
  - the head is popped;
  - outport, neg, zero, over, and the head tag are loaded into the response registers;
  - rsp_valid is set to 1.
- Response without refill: rsp_valid clears when rsp_valid && rsp_ready && !issue.
- Backpressure: while rsp_valid && !rsp_ready, every rsp_* output holds stable and nothing issues.
- Counters:
  - ops_done increments on each rsp_valid && rsp_ready and wraps from 0xFFFF to 0x0000.
  - over_cnt increments on the same handshake when rsp_over=1, and saturates at 0xFF.
- flush: on the next edge the FIFO is emptied (pointers and count go to 0) and rsp_valid goes to 0.
  - A request presented in the flush cycle is not pushed; req_ready is forced to 0 during flush.
  - A response handshake in the flush cycle still counts.
  - Counters are not cleared.
- Reset: RST has priority over flush and over all handshakes. Any operation in progress mid-reset is discarded.

## Timing
- Reset values: req_ready=1 on the first cycle after reset, rsp_valid=0, rsp_result=0, all rsp flags=0, rsp_tag=0, busy=0, ops_done=0, over_cnt=0, FIFO empty.
- Latency: a request pushed at edge N drives the ALU during cycle N+1, is captured at edge N+1, and shows rsp_valid=1 in cycle N+2.
- Throughput: one operation per cycle, sustained, with req_valid and rsp_ready both held high.
- Full: after DEPTH pushes with no pop, req_ready=0. It returns to 1 in the cycle after the first pop.
- Empty with rsp_ready high: rsp_valid drops in the cycle after the handshake.
- The ALU is purely combinational. The single registered stage is the response register, and no flag is sampled from a cycle other than the issue cycle.

## Test plan
- Single ADD: req ADD a=5, b=7, tag=3 accepted at edge 0 → rsp_valid in cycle 2, with rsp_result=12, zero=0, neg=0, over=0, tag=3, and ops_done=1 after the handshake.
- Overflow and counters: ADD 0x7FFFFFFF+1 → result 0x80000000, neg=1, over=1, over_cnt=1. Then SUB 4-4 → result 0, zero=1, over_cnt unchanged.
- Backpressure and full: hold rsp_ready=0 and send 6 requests (tags 0-5).
  - Required: one request captured, DEPTH=4 queued, req_ready=0 with the 6th waiting, rsp_* stable.
  - Then release rsp_ready: responses come out tags 0-5 in order on consecutive cycles.
- Streaming: send 20 back-to-back mixed ops with rsp_ready=1 → 20 consecutive rsp_valid cycles after a 2-cycle fill, with results matching a reference model and ops_done=20.
- Flush and reset: queue 3 requests, then assert flush for one cycle → rsp_valid=0, busy=0 on the next cycle, and no further responses. Repeat using RST mid-stream instead of flush → all outputs return to reset values and ops_done=0.
- Wrap and saturate: preload by running 65,537 handshakes → ops_done=1. Run 300 overflowing ADDs → over_cnt=255.
